// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run controller: run-state encodings,
// display width and the display-mux selector used by the board top level.
// Optional feature macro: RUN_CTRL_CYCLE_LIMIT_EN (adds the LIMIT state).
package core_run_ctrl_pkg;

  // Width of the encoded run state shown on the board display.
  localparam int unsigned RUN_STATE_W = 3;

  // Display data mux selector that routes run_state to the seven-segment display.
  localparam logic [3:0] MUX_DISP_DATA_RUN_ST = 4'd5;

  typedef enum logic [RUN_STATE_W-1:0] {
    RUN_ST_RUN    = 3'd0,
    RUN_ST_PAUSE  = 3'd1,
    RUN_ST_STEP   = 3'd2,
    RUN_ST_HALTED = 3'd3,
    RUN_ST_BRKPT  = 3'd4
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    ,
    RUN_ST_LIMIT  = 3'd5
`endif
  } run_state_e;

endpackage

// File: rtl/aux_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-clock
// pulse on each accepted rising edge of the stable level. Release is silent.
module aux_debounce #(
  parameter int unsigned DebounceCnt = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DebounceCnt + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

  logic [1:0]      sync_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;
  logic            press_q;

  // Synchronise, then accept a new level only after DebounceCnt steady cycles.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      if (sync_q[1] != stable_q) begin
        if (cnt_q == CntLast) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
          press_q  <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any bounce back to the accepted level restarts the stability window.
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/pause/single-step/breakpoint sequencer for the soft core's enable.
// Optional feature macro: RUN_CTRL_CYCLE_LIMIT_EN adds tick_limit and the
// LIMIT state that stops the core after a programmed number of commits.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int unsigned DebounceCnt = 20000,
  parameter int unsigned TickCntBit  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn_resume,
  input  logic                   btn_step,
  input  logic                   core_tick,
  input  logic                   halt,
  input  logic [31:0]            pc,
  input  logic                   bp_valid,
  input  logic [31:0]            bp_addr,
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  input  logic [TickCntBit-1:0]  tick_limit,
`endif
  output logic                   core_en,
  output logic [RUN_STATE_W-1:0] run_state,
  output logic [TickCntBit-1:0]  tick_cnt
);

  run_state_e            state_q;
  logic [TickCntBit-1:0] tick_cnt_q;
  logic                  bp_skip_q;
  logic                  resume_press;
  logic                  step_press;
  logic                  bp_hit;
  logic                  commit;

  aux_debounce #(.DebounceCnt(DebounceCnt)) u_db_resume (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_resume),
    .press_o (resume_press)
  );

  aux_debounce #(.DebounceCnt(DebounceCnt)) u_db_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_step),
    .press_o (step_press)
  );

  // bp_skip lets the breakpointed instruction through exactly once after resume.
  assign bp_hit = bp_valid && (pc == bp_addr) && !bp_skip_q;

  // Enable is combinational so the core is stopped before the breakpoint tick.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    core_en = 1'b0;
    if (state_q == RUN_ST_RUN) begin
      core_en = !bp_hit && !halt;
    end else if (state_q == RUN_ST_STEP) begin
      core_en = !halt;
    end
  end

  assign commit = core_tick && core_en;

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  logic limit_hit;
  // The commit taken at tick_limit-1 is the last one before LIMIT.
  assign limit_hit = commit && (tick_limit != '0) &&
                     (tick_cnt_q == tick_limit - TickCntBit'(1));
`endif

  // Run-state machine plus committed-tick counter and breakpoint skip flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN_ST_RUN;
      tick_cnt_q <= '0;
      bp_skip_q  <= 1'b0;
    end else begin
      if (commit) begin
        tick_cnt_q <= tick_cnt_q + TickCntBit'(1);
        bp_skip_q  <= 1'b0;
      end
      case (state_q)
        RUN_ST_RUN: begin
          if (halt)            state_q <= RUN_ST_HALTED;
          else if (bp_hit)     state_q <= RUN_ST_BRKPT;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
          else if (limit_hit)  state_q <= RUN_ST_LIMIT;
`endif
          else if (step_press) state_q <= RUN_ST_PAUSE;
        end
        RUN_ST_PAUSE: begin
          if (step_press)        state_q <= RUN_ST_STEP;
          else if (resume_press) state_q <= RUN_ST_RUN;
        end
        RUN_ST_STEP: begin
          if (halt)        state_q <= RUN_ST_HALTED;
          else if (commit) state_q <= RUN_ST_PAUSE;
        end
        RUN_ST_BRKPT: begin
          if (step_press) begin
            state_q <= RUN_ST_STEP;
          end else if (resume_press) begin
            state_q   <= RUN_ST_RUN;
            bp_skip_q <= 1'b1;
          end
        end
        RUN_ST_HALTED: begin
          if (resume_press && !halt) state_q <= RUN_ST_RUN;
        end
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
        RUN_ST_LIMIT: begin
          if (step_press) begin
            state_q <= RUN_ST_STEP;
          end else if (resume_press) begin
            state_q    <= RUN_ST_RUN;
            tick_cnt_q <= '0;
          end
        end
`endif
        default: state_q <= RUN_ST_RUN;
      endcase
    end
  end

  assign run_state = state_q;
  assign tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: run, breakpoint, debounced step,
// halt, simultaneous presses, dropped presses, reset mid-debounce, wrap and
// (with RUN_CTRL_CYCLE_LIMIT_EN) the tick limit.
module tb_core_run_ctrl;

  localparam int unsigned DEB = 16;
  localparam int unsigned TCB = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           btn_resume;
  logic           btn_step;
  logic           core_tick;
  logic           halt;
  logic [31:0]    pc;
  logic           bp_valid;
  logic [31:0]    bp_addr;
  logic           core_en;
  logic [2:0]     run_state;
  logic [TCB-1:0] tick_cnt;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  logic [TCB-1:0] tick_limit;
`endif

  int checks = 0;
  int errors = 0;
  logic [TCB-1:0] exp_cnt;
  logic [TCB-1:0] exp_q[$];
  logic [TCB-1:0] e;

  core_run_ctrl #(.DebounceCnt(DEB), .TickCntBit(TCB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_resume (btn_resume),
    .btn_step   (btn_step),
    .core_tick  (core_tick),
    .halt       (halt),
    .pc         (pc),
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    .tick_limit (tick_limit),
`endif
    .core_en    (core_en),
    .run_state  (run_state),
    .tick_cnt   (tick_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One core_tick pulse; the expected counter after it goes to the scoreboard.
  task automatic pulse_tick(input logic commit_exp, input logic [31:0] next_pc);
    @(negedge clk);
    core_tick = 1'b1;
    if (commit_exp) exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back(exp_cnt);
    @(negedge clk);
    core_tick = 1'b0;
    pc = next_pc;
  endtask

  // Optional bounce, hold past the debounce window, release and settle.
  task automatic press(input logic r, input logic s, input int bounces);
    for (int i = 0; i < bounces; i++) begin
      #4;
      if (r) btn_resume = ~btn_resume;
      if (s) btn_step = ~btn_step;
    end
    @(negedge clk);
    if (r) btn_resume = 1'b1;
    if (s) btn_step = 1'b1;
    repeat (DEB + 8) @(negedge clk);
    btn_resume = 1'b0;
    btn_step = 1'b0;
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_resume = 1'b0; btn_step = 1'b0; core_tick = 1'b0;
    halt = 1'b0; pc = 32'h0000_3000; bp_valid = 1'b0; bp_addr = '0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    tick_limit = '0;
`endif
    exp_cnt = '0; exp_q.delete();
    repeat (3) @(negedge clk);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL reset run_state: got %0d expected 0", run_state); end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL reset tick_cnt: got %0d expected 0", tick_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL reset core_en: got %0b expected 1", core_en); end
  endtask

  task automatic test_run();
    for (int i = 0; i < 5; i++) begin
      checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL run core_en[%0d]: got %0b expected 1", i, core_en); end
      pulse_tick(1'b1, pc + 32'd4);
      e = exp_q.pop_front();
      checks++; if (tick_cnt !== e) begin errors++; $display("FAIL run tick_cnt[%0d]: got %0d expected %0d", i, tick_cnt, e); end
    end
    checks++; if (tick_cnt !== 8'd5) begin errors++; $display("FAIL run final tick_cnt: got %0d expected 5", tick_cnt); end
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL run run_state: got %0d expected 0", run_state); end
  endtask

  task automatic test_breakpoint();
    bp_addr = 32'h0000_3010; bp_valid = 1'b1; pc = 32'h0000_3008;
    pulse_tick(1'b1, 32'h0000_300C);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL bp pre tick_cnt: got %0d expected %0d", tick_cnt, e); end
    pulse_tick(1'b1, 32'h0000_3010);
    e = exp_q.pop_front();
    #1;
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL bp core_en drop: got %0b expected 0", core_en); end
    @(negedge clk);
    checks++; if (run_state !== 3'd4) begin errors++; $display("FAIL bp run_state: got %0d expected 4", run_state); end
    pulse_tick(1'b0, 32'h0000_3010);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL bp frozen tick_cnt: got %0d expected %0d", tick_cnt, e); end
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL bp resume run_state: got %0d expected 0", run_state); end
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL bp skip core_en: got %0b expected 1", core_en); end
    pulse_tick(1'b1, 32'h0000_3014);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL bp skip commit tick_cnt: got %0d expected %0d", tick_cnt, e); end
    @(negedge clk);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL bp continue run_state: got %0d expected 0", run_state); end
    pulse_tick(1'b1, 32'h0000_3018);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL bp continue tick_cnt: got %0d expected %0d", tick_cnt, e); end
    bp_valid = 1'b0;
  endtask

  task automatic test_step_bounce();
    press(1'b0, 1'b1, 10);
    checks++; if (run_state !== 3'd1) begin errors++; $display("FAIL step bounce run_state: got %0d expected 1", run_state); end
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL pause core_en: got %0b expected 0", core_en); end
    pulse_tick(1'b0, pc);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL pause tick_cnt: got %0d expected %0d", tick_cnt, e); end
    press(1'b0, 1'b1, 0);
    checks++; if (run_state !== 3'd2) begin errors++; $display("FAIL step run_state: got %0d expected 2", run_state); end
    pulse_tick(1'b1, pc + 32'd4);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL step commit tick_cnt: got %0d expected %0d", tick_cnt, e); end
    checks++; if (run_state !== 3'd1) begin errors++; $display("FAIL step back to pause: got %0d expected 1", run_state); end
  endtask

  task automatic test_halt();
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL halt pre run_state: got %0d expected 0", run_state); end
    halt = 1'b1;
    #1;
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL halt core_en: got %0b expected 0", core_en); end
    @(negedge clk);
    checks++; if (run_state !== 3'd3) begin errors++; $display("FAIL halt run_state: got %0d expected 3", run_state); end
    pulse_tick(1'b0, pc);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL halt tick_cnt: got %0d expected %0d", tick_cnt, e); end
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd3) begin errors++; $display("FAIL halt held resume: got %0d expected 3", run_state); end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL halted released core_en: got %0b expected 0", core_en); end
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL halt release resume: got %0d expected 0", run_state); end
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b1, 0);
    checks++; if (run_state !== 3'd1) begin errors++; $display("FAIL simul pre run_state: got %0d expected 1", run_state); end
    press(1'b1, 1'b1, 0);
    checks++; if (run_state !== 3'd2) begin errors++; $display("FAIL simul run_state: got %0d expected 2", run_state); end
    pulse_tick(1'b1, pc + 32'd4);
    e = exp_q.pop_front();
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL simul tick_cnt: got %0d expected %0d", tick_cnt, e); end
  endtask

  task automatic test_dropped();
    press(1'b0, 1'b1, 0);
    checks++; if (run_state !== 3'd2) begin errors++; $display("FAIL drop step run_state: got %0d expected 2", run_state); end
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd2) begin errors++; $display("FAIL drop resume in step: got %0d expected 2", run_state); end
    pulse_tick(1'b1, pc + 32'd4);
    e = exp_q.pop_front();
    repeat (2) @(negedge clk);
    checks++; if (run_state !== 3'd1) begin errors++; $display("FAIL drop not queued: got %0d expected 1", run_state); end
    checks++; if (tick_cnt !== e) begin errors++; $display("FAIL drop tick_cnt: got %0d expected %0d", tick_cnt, e); end
    press(1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    btn_step = 1'b1;
    repeat (DEB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL midreset run_state: got %0d expected 0", run_state); end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL midreset tick_cnt: got %0d expected 0", tick_cnt); end
    rst_n = 1'b1;
    exp_cnt = '0; exp_q.delete();
    repeat (2) @(negedge clk);
    btn_step = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL midreset no press: got %0d expected 0", run_state); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      pulse_tick(1'b1, pc);
      e = exp_q.pop_front();
      checks++; if (tick_cnt !== e) begin errors++; $display("FAIL wrap tick_cnt[%0d]: got %0d expected %0d", i, tick_cnt, e); end
    end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL wrap final: got %0d expected 0", tick_cnt); end
  endtask

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  task automatic test_limit();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0; exp_q.delete();
    tick_limit = 8'd8;
    for (int i = 0; i < 8; i++) begin
      checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL limit early state[%0d]: got %0d expected 0", i, run_state); end
      pulse_tick(1'b1, pc + 32'd4);
      e = exp_q.pop_front();
      checks++; if (tick_cnt !== e) begin errors++; $display("FAIL limit tick_cnt[%0d]: got %0d expected %0d", i, tick_cnt, e); end
    end
    checks++; if (run_state !== 3'd5) begin errors++; $display("FAIL limit run_state: got %0d expected 5", run_state); end
    checks++; if (tick_cnt !== 8'd8) begin errors++; $display("FAIL limit tick_cnt: got %0d expected 8", tick_cnt); end
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL limit core_en: got %0b expected 0", core_en); end
    press(1'b1, 1'b0, 0);
    checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL limit resume state: got %0d expected 0", run_state); end
    checks++; if (tick_cnt !== '0) begin errors++; $display("FAIL limit resume tick_cnt: got %0d expected 0", tick_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_breakpoint();
    test_step_bounce();
    test_halt();
    test_simultaneous();
    test_dropped();
    test_reset_mid();
    test_wrap();
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    test_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
